ps2_keyevent: RTL and testbench



---
 rtl/ps2_keyevent.sv | 187 ++++++++++++++++++
 tb/tb_ps2_keyevent.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyevent.sv
// PS/2 key-event decoder: pulls bytes from the PS/2 receiver, strips E0/F0/E1 prefixes and queues {ext, brk, code} events.
// Optional build macro PS2KEV_TYPEMATIC_FILTER_EN suppresses typematic repeat makes via a 512-entry held table.
module ps2_keyevent #(
    parameter int FIFO_DEPTH = 4,
    parameter int PAUSE_SKIP = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_dsr,
    input  logic [7:0]                    rx_q,
    output logic                          rx_rden,
    input  logic                          rx_overflow,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_brk,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);
    localparam logic [SW-1:0] SKIP_INIT  = SW'(PAUSE_SKIP);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [63:0]   REPLY_CODES = 64'h00AA_EEFA_FCFD_FEFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DECODE
    } state_t;

    state_t          state_reg;
    logic [7:0]      byte_reg;
    logic            ext_f_reg;
    logic            brk_f_reg;
    logic [SW-1:0]   skip_cnt_reg;
    logic            rden_last_reg;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    logic            fifo_full;
    logic            pop_en;
    logic            push_en;
    logic [9:0]      push_data;
    logic [9:0]      head;

    logic [7:0]      reply_hit;
    logic            is_reply;
    logic            is_e0;
    logic            is_e1;
    logic            is_f0;
    logic            in_decode;
    logic            skipping;
    logic            prefix_pending;
    logic            pause_ev;
    logic            key_ev;

    // Keyboard reply bytes (BAT, ACK, echo, resend, errors) are only dropped when no prefix precedes them.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reply
            assign reply_hit[gi] = (byte_reg == REPLY_CODES[8*gi +: 8]);
        end
    endgenerate

    assign is_reply       = |reply_hit;
    assign is_e0          = (byte_reg == 8'hE0);
    assign is_e1          = (byte_reg == 8'hE1);
    assign is_f0          = (byte_reg == 8'hF0);
    assign in_decode      = (state_reg == DECODE);
    assign skipping       = (skip_cnt_reg != '0);
    assign prefix_pending = ext_f_reg | brk_f_reg;

    assign pause_ev  = in_decode & skipping & (skip_cnt_reg == SW'(1));
    assign key_ev    = in_decode & ~skipping & ~is_e1 & ~is_e0 & ~is_f0 & (prefix_pending | ~is_reply);
    assign push_data = pause_ev ? {2'b10, 8'h77} : {ext_f_reg, brk_f_reg, byte_reg};

`ifdef PS2KEV_TYPEMATIC_FILTER_EN
    logic [511:0] held_reg;
    logic         held_hit;

    assign held_hit = held_reg[{ext_f_reg, byte_reg}];
    assign push_en  = pause_ev | (key_ev & (brk_f_reg | ~held_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            held_reg <= '0;
        end else if (key_ev) begin
            held_reg[{ext_f_reg, byte_reg}] <= ~brk_f_reg;
        end
    end
`else
    assign push_en = pause_ev | key_ev;
`endif

    assign fifo_full = (count_reg == DEPTH_C);
    // Read strobe is a single-cycle pulse; rx_q is then valid during FETCH.
    assign rx_rden   = ~reset & (state_reg == IDLE) & rx_dsr & ~fifo_full & ~rden_last_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            byte_reg      <= '0;
            ext_f_reg     <= 1'b0;
            brk_f_reg     <= 1'b0;
            skip_cnt_reg  <= '0;
            rden_last_reg <= 1'b0;
        end else begin
            rden_last_reg <= rx_rden;
            case (state_reg)
                IDLE: begin
                    if (rx_rden) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    byte_reg  <= rx_q;
                    state_reg <= DECODE;
                end
                DECODE: begin
                    state_reg <= IDLE;
                    if (skipping) begin
                        skip_cnt_reg <= skip_cnt_reg - SW'(1);
                    end else if (is_e1) begin
                        skip_cnt_reg <= SKIP_INIT;
                        ext_f_reg    <= 1'b0;
                        brk_f_reg    <= 1'b0;
                    end else if (is_e0) begin
                        ext_f_reg <= 1'b1;
                    end else if (is_f0) begin
                        brk_f_reg <= 1'b1;
                    end else begin
                        ext_f_reg <= 1'b0;
                        brk_f_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
            // An abandoned frame invalidates any partial prefix; the byte in flight still decodes.
            if (rx_overflow) begin
                ext_f_reg    <= 1'b0;
                brk_f_reg    <= 1'b0;
                skip_cnt_reg <= '0;
            end
        end
    end

    assign pop_en = ev_valid & ev_ready;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign ev_valid = (count_reg != '0);
    assign ev_count = count_reg;
    assign ev_code  = ev_valid ? head[7:0] : 8'h00;
    assign ev_ext   = ev_valid & head[9];
    assign ev_brk   = ev_valid & head[8];

endmodule

// File: tb/tb_ps2_keyevent.sv
// Self-checking bench for ps2_keyevent: byte-sequence table with an event scoreboard plus hand-written corner cases.
module tb_ps2_keyevent;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_dsr;
    logic [7:0] rx_q;
    logic       rx_rden;
    logic       rx_overflow;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic [2:0] ev_count;

    always #5 clk = ~clk;

    ps2_keyevent #(.FIFO_DEPTH(4), .PAUSE_SKIP(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_dsr      (rx_dsr),
        .rx_q        (rx_q),
        .rx_rden     (rx_rden),
        .rx_overflow (rx_overflow),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_ext      (ev_ext),
        .ev_brk      (ev_brk),
        .ev_count    (ev_count)
    );

    logic [7:0] byte_q[$];
    logic [9:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rden_cnt = 0;

    typedef struct packed {
        int          n;
        logic [63:0] b;
        int          ne;
        logic [59:0] e;
    } vec_t;

    vec_t tbl[16];
    int   nv = 0;

    // Receiver model: byte appears on rx_q the cycle after the read strobe.
    always @(posedge clk) begin
        if (rx_rden) begin
            rden_cnt <= rden_cnt + 1;
            if (byte_q.size() != 0) rx_q <= byte_q.pop_front();
            else                    rx_q <= 8'h00;
        end
    end

    always @(negedge clk) begin
        rx_dsr <= (byte_q.size() != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard: every consumer pop must match the oldest expected event.
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got ext=%0d brk=%0d code=%0h expected none",
                         ev_ext, ev_brk, ev_code);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                $display("event ext=%0d brk=%0d code=%02h", ev_ext, ev_brk, ev_code);
                chk("event", {22'd0, ev_ext, ev_brk, ev_code}, {22'd0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int n, input logic [63:0] b);
        for (int i = 0; i < n; i++) byte_q.push_back(b[8*(n-1-i) +: 8]);
    endtask

    task automatic expect_ev(input int n, input logic [59:0] e);
        for (int i = 0; i < n; i++) exp_q.push_back(e[10*(n-1-i) +: 10]);
    endtask

    task automatic settle(input string name);
        int k = 0;
        while ((byte_q.size() != 0 || exp_q.size() != 0) && k < 400) begin
            tick(1);
            k++;
        end
        tick(12);
        chk({name, "_bytes_read"}, byte_q.size(), 0);
        chk({name, "_events_seen"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic add(input int n, input logic [63:0] b, input int ne, input logic [59:0] e);
        tbl[nv] = '{n: n, b: b, ne: ne, e: e};
        nv++;
    endtask

    initial begin
        int rb;
        reset       = 1'b1;
        rx_overflow = 1'b0;
        ev_ready    = 1'b0;
        rx_q        = 8'h00;
        rx_dsr      = 1'b0;

        add(1, 64'h1C,               1, 60'h01C);
        add(3, 64'hE0F075,           1, 60'h375);
        add(1, 64'h75,               1, 60'h075);
        add(8, 64'hE11477E1F014F077, 1, 60'h277);
        add(1, 64'hAA,               0, 60'h0);
        add(1, 64'hFA,               0, 60'h0);
        add(2, 64'hF0AA,             1, 60'h1AA);
        add(2, 64'hE01F,             1, 60'h21F);
        add(3, 64'h00FFEE,           0, 60'h0);
        add(2, 64'hE0FA,             1, 60'h2FA);
`ifdef PS2KEV_TYPEMATIC_FILTER_EN
        add(6, 64'h1C1C1CF01C1C,     3, {10'h01C, 10'h11C, 10'h01C});
`else
        add(6, 64'h1C1C1CF01C1C,     5, {10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C});
`endif
        add(3, 64'hF0E011,           1, 60'h311);

        tick(3);
        reset = 1'b0;
        tick(1);
        chk("reset_rden",  {31'd0, rx_rden},  0);
        chk("reset_valid", {31'd0, ev_valid}, 0);
        chk("reset_count", {29'd0, ev_count}, 0);
        chk("reset_code",  {24'd0, ev_code},  0);
        chk("reset_ext",   {31'd0, ev_ext},   0);
        chk("reset_brk",   {31'd0, ev_brk},   0);

        // Single make held in the FIFO
        rb = rden_cnt;
        send(1, 64'h1C);
        tick(12);
        $display("single make: rden pulses=%0d count=%0d", rden_cnt - rb, ev_count);
        chk("single_rden_pulses", rden_cnt - rb, 1);
        chk("single_valid", {31'd0, ev_valid}, 1);
        chk("single_code",  {24'd0, ev_code},  32'h1C);
        chk("single_ext",   {31'd0, ev_ext},   0);
        chk("single_brk",   {31'd0, ev_brk},   0);
        chk("single_count", {29'd0, ev_count}, 1);
        expect_ev(1, 60'h01C);
        ev_ready = 1'b1;
        settle("single");

        for (int v = 0; v < nv; v++) begin
            $display("vector %0d: bytes=%0d expected_events=%0d", v, tbl[v].n, tbl[v].ne);
            expect_ev(tbl[v].ne, tbl[v].e);
            send(tbl[v].n, tbl[v].b);
            settle($sformatf("vec%0d", v));
        end

        // FIFO full back-pressure
        ev_ready = 1'b0;
        rb = rden_cnt;
        expect_ev(5, {10'h015, 10'h016, 10'h017, 10'h018, 10'h019});
        send(5, 64'h1516171819);
        tick(40);
        $display("full: count=%0d waiting=%0d rden pulses=%0d", ev_count, byte_q.size(), rden_cnt - rb);
        chk("full_count",   {29'd0, ev_count}, 4);
        chk("full_waiting", byte_q.size(), 1);
        chk("full_rden",    rden_cnt - rb, 4);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        tick(12);
        chk("refill_rden",  rden_cnt - rb, 5);
        chk("refill_count", {29'd0, ev_count}, 4);
        chk("refill_head",  {24'd0, ev_code}, 32'h16);
        ev_ready = 1'b1;
        settle("full");

        // Overflow clears a pending E0
        send(1, 64'hE0);
        tick(10);
        rx_overflow = 1'b1;
        tick(1);
        rx_overflow = 1'b0;
        $display("overflow: sending 6B after E0 + overflow");
        expect_ev(1, 60'h06B);
        send(1, 64'h6B);
        settle("overflow");

        // Overflow aborts a Pause skip window
        send(2, 64'hE114);
        tick(12);
        rx_overflow = 1'b1;
        tick(1);
        rx_overflow = 1'b0;
        expect_ev(1, 60'h02D);
        send(1, 64'h2D);
        settle("overflow_pause");

        // Reset empties the FIFO and drops prefixes
        ev_ready = 1'b0;
        send(1, 64'h1C);
        tick(12);
        chk("prereset_count", {29'd0, ev_count}, 1);
        do_reset();
        chk("midreset_count", {29'd0, ev_count}, 0);
        chk("midreset_valid", {31'd0, ev_valid}, 0);
        send(1, 64'hE0);
        tick(12);
        do_reset();
        ev_ready = 1'b1;
        $display("reset: sending 6B after E0 + reset");
        expect_ev(1, 60'h06B);
        send(1, 64'h6B);
        settle("reset_prefix");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
